// File: rtl/mips_mem_responder.sv
// mips_mem_responder: unified I/D memory behind a valid/ready
// request/response handshake, with a fixed number of wait states.
//
// Ports:
//   cclk, rst          clock; synchronous active-high reset
//   req_valid/ready    request handshake
//   req_we/be          write flag, per-byte write enables
//   req_addr/wdata     byte address, write data
//   rsp_valid/ready    response handshake
//   rsp_rdata/err      read data (0 for writes/errors), error flag

module mips_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        cclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W =
    30'(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0
                       : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;

  logic        cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        rsp_done;

  logic        op_we;
  logic [3:0]  op_be;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_err;
  logic [AW-1:0] op_idx;
  logic [31:0] rdata_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    rsp_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          rsp_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero wait states the memory op
  // happens on the accept edge, so the
  // live request feeds it directly.
  always_comb begin
    op_we    = cap_we;
    op_be    = cap_be;
    op_addr  = cap_addr;
    op_wdata = cap_wdata;
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_be    = req_be;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  // Full word-index compare: high address
  // bits never wrap onto a valid word.
  assign op_err =
    (|op_addr[1:0]) |
    (op_addr[31:2] >= DEPTH_W);
  assign op_idx = op_addr[AW+1:2];

  always_comb begin
    rdata_d = 32'd0;
    if (!op_err && !op_we) begin
      rdata_d = mem[op_idx];
    end
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      cap_we    <= 1'b0;
      cap_be    <= 4'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_we    <= req_we;
        cap_be    <= req_be;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_rdata <= rdata_d;
        rsp_err   <= op_err;
      end else if (rsp_done) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Array is never reset; a reset on the
  // commit edge aborts the write.
  always_ff @(posedge cclk) begin
    if (!rst && enter_resp &&
        !op_err && op_we) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) begin
          mem[op_idx][8*b +: 8] <=
            op_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed checks of
// three responder builds (1, 0, 3 wait states).

module tb_mips_mem_responder;

  logic        clk;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [3:0]  req_be    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks   = 0;
  int failures = 0;

  mips_mem_responder #(
    .DEPTH_WORDS(256), .WAIT_STATES(1)
  ) u_ws1 (
    .cclk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]),
    .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_be(req_be[0]),
    .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  mips_mem_responder #(
    .DEPTH_WORDS(256), .WAIT_STATES(0)
  ) u_ws0 (
    .cclk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]),
    .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_be(req_be[1]),
    .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  mips_mem_responder #(
    .DEPTH_WORDS(256), .WAIT_STATES(3)
  ) u_ws3 (
    .cclk(clk), .rst(rst[2]),
    .req_valid(req_valid[2]),
    .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_be(req_be[2]),
    .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [3:0] be,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] rd,
    input logic er);
    vec_t v;
    v.we = we; v.be = be; v.addr = a;
    v.wdata = d; v.rdata = rd; v.err = er;
    return v;
  endfunction

  task automatic drive(input int i,
                       input logic we,
                       input logic [3:0] be,
                       input logic [31:0] a,
                       input logic [31:0] d);
    req_we[i]    = we;
    req_be[i]    = be;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
  endtask

  // Returns after the accept edge.
  task automatic wait_accept(input int i);
    int n;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: dut %0d", i);
    end
    @(posedge clk);
  endtask

  // lat = accept edge to first edge that
  // samples rsp_valid high.
  task automatic wait_rsp(input int i,
                          output int lat);
    lat = 1;
    while (!rsp_valid[i] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic xact(input int i,
                      input logic we,
                      input logic [3:0] be,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output logic er,
                      output int lat);
    @(negedge clk);
    drive(i, we, be, a, d);
    rsp_ready[i] = 1'b1;
    wait_accept(i);
    @(negedge clk);
    req_valid[i] = 1'b0;
    wait_rsp(i, lat);
    rd = rsp_rdata[i];
    er = rsp_err[i];
    @(posedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_be[i]    = 4'd0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      rsp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk1("rst_req_ready", req_ready[i], 1'b1);
      chk1("rst_rsp_valid", rsp_valid[i], 1'b0);
      chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      chk1("rst_rsp_err", rsp_err[i], 1'b0);
    end

    vecs.push_back(mk(1, 4'hF, 32'h10,
      32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h10,
      32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 4'h5, 32'h10,
      32'h11223344, 32'h0, 0));
    vecs.push_back(mk(0, 4'h0, 32'h10,
      32'h0, 32'hDE22BE44, 0));
    vecs.push_back(mk(1, 4'hF, 32'h0,
      32'h01234567, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h12,
      32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 4'hF, 32'h400,
      32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 4'hF, 32'h400,
      32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk(1, 4'hF, 32'h11,
      32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 4'hF, 32'h0,
      32'h0, 32'h01234567, 0));
    vecs.push_back(mk(0, 4'hF, 32'h10,
      32'h0, 32'hDE22BE44, 0));
    vecs.push_back(mk(1, 4'hF, 32'h3FC,
      32'h5A5A5A5A, 32'h0, 0));
    vecs.push_back(mk(1, 4'h0, 32'h3FC,
      32'hAAAAAAAA, 32'h0, 0));
    vecs.push_back(mk(0, 4'h0, 32'h3FC,
      32'h0, 32'h5A5A5A5A, 0));
    vecs.push_back(mk(1, 4'hA, 32'h0,
      32'hAABBCCDD, 32'h0, 0));
    vecs.push_back(mk(0, 4'h0, 32'h0,
      32'h0, 32'hAA23CC67, 0));
    vecs.push_back(mk(0, 4'h0, 32'h80000010,
      32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 4'h0, 32'h3FD,
      32'h0, 32'h0, 1));

    foreach (vecs[k]) begin
      xact(0, vecs[k].we, vecs[k].be,
           vecs[k].addr, vecs[k].wdata,
           rd, er, lat);
      chk($sformatf("vec%0d_rdata", k),
          rd, vecs[k].rdata);
      chk1($sformatf("vec%0d_err", k),
           er, vecs[k].err);
      chk($sformatf("vec%0d_lat", k),
          32'(lat), 32'd2);
    end

    // Backpressure with a second request
    // held on the bus.
    xact(0, 1, 4'hF, 32'h20, 32'h13579BDF,
         rd, er, lat);
    @(negedge clk);
    drive(0, 0, 4'h0, 32'h20, 32'h0);
    rsp_ready[0] = 1'b0;
    wait_accept(0);
    @(negedge clk);
    req_addr[0] = 32'h10;
    wait_rsp(0, lat);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk1("bp_valid", rsp_valid[0], 1'b1);
      chk("bp_rdata", rsp_rdata[0],
          32'h13579BDF);
      chk1("bp_req_ready", req_ready[0], 1'b0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("bp_valid_clr", rsp_valid[0], 1'b0);
    chk("bp_rdata_clr", rsp_rdata[0], 32'd0);
    chk1("bp_accept_next", req_ready[0], 1'b1);
    chk1("bp_second_held", req_valid[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    chk("bp2_lat", 32'(lat), 32'd2);
    chk("bp2_rdata", rsp_rdata[0],
        32'hDE22BE44);
    @(posedge clk);

    // Zero wait states.
    xact(1, 1, 4'hF, 32'h10, 32'hDEADBEEF,
         rd, er, lat);
    chk("ws0_wr_lat", 32'(lat), 32'd1);
    chk1("ws0_wr_err", er, 1'b0);
    xact(1, 0, 4'h0, 32'h10, 32'h0,
         rd, er, lat);
    chk("ws0_rd_lat", 32'(lat), 32'd1);
    chk("ws0_rd_data", rd, 32'hDEADBEEF);

    // Three wait states.
    xact(2, 1, 4'hF, 32'h20, 32'h0,
         rd, er, lat);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    xact(2, 0, 4'h0, 32'h20, 32'h0,
         rd, er, lat);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_rd_data", rd, 32'h0);

    // Reset in the middle of WAIT.
    @(negedge clk);
    drive(2, 1, 4'hF, 32'h20, 32'hCAFEF00D);
    wait_accept(2);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    chk1("rstw_req_ready", req_ready[2], 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid[2]) seen = 1'b1;
      @(negedge clk);
    end
    chk1("rstw_no_rsp", seen, 1'b0);
    xact(2, 0, 4'h0, 32'h20, 32'h0,
         rd, er, lat);
    chk("rstw_rd_data", rd, 32'h0);
    chk1("rstw_rd_err", er, 1'b0);

    // Reset with req_valid high.
    @(negedge clk);
    rst[1] = 1'b1;
    drive(1, 0, 4'h0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk1("rstv_no_accept", rsp_valid[1], 1'b0);
    req_valid[1] = 1'b0;
    rst[1] = 1'b0;

    // Reset during RESP keeps the write.
    @(negedge clk);
    drive(1, 1, 4'hF, 32'h40, 32'h0BADCAFE);
    rsp_ready[1] = 1'b0;
    wait_accept(1);
    @(negedge clk);
    chk1("rstr_valid", rsp_valid[1], 1'b1);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    chk1("rstr_dropped", rsp_valid[1], 1'b0);
    xact(1, 0, 4'h0, 32'h40, 32'h0,
         rd, er, lat);
    chk("rstr_rd_data", rd, 32'h0BADCAFE);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
